// File: rtl/fp_mult_round_pack.sv
// rtl/fp_mult_round_pack.sv - single-precision multiplier final stage: RNE rounding, special cases, pack
// Two-entry valid/ready pipeline: stage 1 rounds, stage 2 resolves specials/range and packs.
module fp_mult_round_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [8:0]  e_in,
    input  logic [22:0] m_in,
    input  logic        g_in,
    input  logic        r_in,
    input  logic        sticky_in,
    input  logic        nan_in,
    input  logic        inf_in,
    input  logic        zero_in,
    input  logic        unf_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z,
    output logic        ovf,
    output logic        unf,
    output logic        inexact
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        s1_adv;
    logic        s1_load;
    logic        s2_load;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_q;
    logic [8:0]  s1_e_q;
    logic        s1_carry_q;
    logic [22:0] s1_frac_q;
    logic        s1_nan_q, s1_inf_q, s1_zero_q, s1_unf_q;
    logic        s1_inexact_q;

    logic        round_up;
    logic        carry_d;
    logic [22:0] frac_d;
    logic        inexact_d;

    logic        s2_valid_q, s2_valid_d;
    logic [31:0] z_q, z_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        inexact_q, inexact_d2;

    logic [8:0]  e_fin;
    logic [22:0] frac_fin;

    assign s1_adv   = ~s2_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s1_adv;
    assign s1_load  = in_ready & in_valid;
    assign s2_load  = s1_adv & s1_valid_q;

    // The hidden 1 at bit 23 carries out exactly when the fraction overflows,
    // so a 24-bit add of the fraction alone reproduces the 25-bit sum's carry.
    always_comb begin
        round_up            = g_in & (r_in | sticky_in | m_in[0]);
        {carry_d, frac_d}   = {1'b0, m_in} + {23'd0, round_up};
        inexact_d           = g_in | r_in | sticky_in;
        s1_valid_d          = in_ready ? in_valid : s1_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_e_q       <= 9'd0;
            s1_carry_q   <= 1'b0;
            s1_frac_q    <= 23'd0;
            s1_nan_q     <= 1'b0;
            s1_inf_q     <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_unf_q     <= 1'b0;
            s1_inexact_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_load) begin
                s1_sign_q    <= sign_in;
                s1_e_q       <= e_in;
                s1_carry_q   <= carry_d;
                s1_frac_q    <= frac_d;
                s1_nan_q     <= nan_in;
                s1_inf_q     <= inf_in;
                s1_zero_q    <= zero_in;
                s1_unf_q     <= unf_in;
                s1_inexact_q <= inexact_d;
            end
        end
    end

    // Renormalize on rounding carry, then pick the result by special-case priority.
    always_comb begin
        e_fin      = s1_e_q + {8'd0, s1_carry_q};
        frac_fin   = s1_carry_q ? 23'd0 : s1_frac_q;
        z_d        = {s1_sign_q, e_fin[7:0], frac_fin};
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        inexact_d2 = s1_inexact_q;
        if (s1_nan_q) begin
            z_d        = QNAN;
            inexact_d2 = 1'b0;
        end else if (s1_inf_q) begin
            z_d        = {s1_sign_q, 8'hFF, 23'd0};
            inexact_d2 = 1'b0;
        end else if (s1_zero_q) begin
            z_d        = {s1_sign_q, 31'd0};
            inexact_d2 = 1'b0;
        end else if (s1_unf_q || (e_fin == 9'd0)) begin
            z_d        = {s1_sign_q, 31'd0};
            unf_d      = 1'b1;
            inexact_d2 = 1'b1;
        end else if (e_fin[8] || (e_fin[7:0] == 8'hFF)) begin
            z_d        = {s1_sign_q, 8'hFF, 23'd0};
            ovf_d      = 1'b1;
            inexact_d2 = 1'b1;
        end
        s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            z_q        <= 32'd0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inexact_q  <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                z_q       <= z_d;
                ovf_q     <= ovf_d;
                unf_q     <= unf_d;
                inexact_q <= inexact_d2;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign z         = z_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp_mult_round_pack.sv
// tb/tb_fp_mult_round_pack.sv - scoreboard bench for fp_mult_round_pack
module tb_fp_mult_round_pack;

    typedef struct packed {
        logic        sign;
        logic [8:0]  e;
        logic [22:0] m;
        logic        g, r, s, nan, inf, zero, unf;
    } op_t;

    typedef struct packed {
        logic [31:0] z;
        logic        ovf, unf, inx;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, ovf, unf, inexact;
    logic [31:0] z;
    op_t         cur = '0;

    int   tests = 0;
    int   fails = 0;
    res_t sb[$];
    bit   rand_on = 1'b0;
    bit   stalled_prev = 1'b0;
    res_t held_prev;

    always #5 clk = ~clk;

    fp_mult_round_pack dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(cur.sign), .e_in(cur.e), .m_in(cur.m),
        .g_in(cur.g), .r_in(cur.r), .sticky_in(cur.s),
        .nan_in(cur.nan), .inf_in(cur.inf), .zero_in(cur.zero), .unf_in(cur.unf),
        .out_valid(out_valid), .out_ready(out_ready), .z(z),
        .ovf(ovf), .unf(unf), .inexact(inexact)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: RNE by comparing the discarded bits against one half ulp.
    function automatic res_t model(op_t o);
        res_t        res;
        int unsigned q;
        int unsigned rem;
        int          e;
        q   = (32'd1 << 23) | 32'(o.m);
        rem = 32'({o.g, o.r, o.s});
        if (rem > 4 || (rem == 4 && (q % 2) == 1)) q = q + 1;
        e = int'(o.e);
        if (q == (32'd1 << 24)) begin
            e = e + 1;
            q = 32'd1 << 23;
        end
        res.ovf = 1'b0;
        res.unf = 1'b0;
        res.inx = (rem != 0);
        if (o.nan) begin
            res.z = 32'h7FC0_0000; res.inx = 1'b0;
        end else if (o.inf) begin
            res.z = {o.sign, 8'hFF, 23'd0}; res.inx = 1'b0;
        end else if (o.zero) begin
            res.z = {o.sign, 31'd0}; res.inx = 1'b0;
        end else if (o.unf || e == 0) begin
            res.z = {o.sign, 31'd0}; res.unf = 1'b1; res.inx = 1'b1;
        end else if (e >= 255) begin
            res.z = {o.sign, 8'hFF, 23'd0}; res.ovf = 1'b1; res.inx = 1'b1;
        end else begin
            res.z = {o.sign, e[7:0], q[22:0]};
        end
        return res;
    endfunction

    function automatic op_t mk(logic sg, logic [8:0] e, logic [22:0] m, logic g, logic r, logic s,
                               logic nan, logic inf, logic zero, logic uf);
        op_t o;
        o.sign = sg; o.e = e; o.m = m; o.g = g; o.r = r; o.s = s;
        o.nan = nan; o.inf = inf; o.zero = zero; o.unf = uf;
        return o;
    endfunction

    function automatic op_t rnd();
        op_t o;
        o = '0;
        case ($urandom % 6)
            0: o.e = 9'h000;
            1: o.e = 9'h001;
            2: o.e = 9'h0FE;
            3: o.e = 9'h0FF;
            4: o.e = 9'h100 + 9'($urandom % 255);
            default: o.e = 9'($urandom % 256);
        endcase
        o.m    = ($urandom % 4 == 0) ? 23'h7FFFFF : 23'($urandom);
        o.sign = 1'($urandom);
        o.g    = 1'($urandom);
        o.r    = 1'($urandom);
        o.s    = 1'($urandom);
        o.nan  = ($urandom % 16 == 0);
        o.inf  = ($urandom % 16 == 0);
        o.zero = ($urandom % 16 == 0);
        o.unf  = ($urandom % 16 == 0);
        return o;
    endfunction

    // Input side of the scoreboard: push the expected result at every accepted transfer.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) sb.push_back(model(cur));
    end

    // Output side: pop and compare every output transfer; also check hold-while-stalled.
    always @(negedge clk) begin
        res_t act;
        act = '{z: z, ovf: ovf, unf: unf, inx: inexact};
        if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                check("stall_valid_hold", 64'(out_valid), 64'd1);
                check("stall_data_hold", 64'(act), 64'(held_prev));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_output: got %h expected none", act);
                end else begin
                    check("result", 64'(act), 64'(sb.pop_front()));
                end
            end
            stalled_prev = out_valid && !out_ready;
            held_prev    = act;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input op_t o);
        int n;
        cur = o;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                tests++; fails++;
                $display("FAIL send_timeout: got in_ready 0 expected 1");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] ez, input logic eo, input logic eu, input logic ei);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                seen = 1'b1;
                check(name, {z, ovf, unf, inexact}, {ez, eo, eu, ei});
            end
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL %s_timeout: got no out_valid expected result", name);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        op_t bp[5];
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", {z, ovf, unf, inexact}, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        send(mk(0, 9'h07F, 23'h7FFFFF, 1, 0, 0, 0, 0, 0, 0)); idle();
        expect_out("tie_odd_carry", 32'h4000_0000, 0, 0, 1);
        send(mk(0, 9'h07F, 23'h000000, 1, 0, 0, 0, 0, 0, 0)); idle();
        expect_out("tie_even", 32'h3F80_0000, 0, 0, 1);
        send(mk(0, 9'h07F, 23'h000000, 1, 0, 1, 0, 0, 0, 0)); idle();
        expect_out("above_half", 32'h3F80_0001, 0, 0, 1);
        send(mk(1, 9'h0FE, 23'h7FFFFF, 1, 1, 0, 0, 0, 0, 0)); idle();
        expect_out("round_ovf", 32'hFF80_0000, 1, 0, 1);
        send(mk(1, 9'h07F, 23'h000005, 0, 0, 0, 0, 0, 0, 1)); idle();
        expect_out("unf_in", 32'h8000_0000, 0, 1, 1);
        send(mk(0, 9'h000, 23'h123456, 0, 0, 0, 0, 0, 0, 0)); idle();
        expect_out("e_zero", 32'h0000_0000, 0, 1, 1);
        send(mk(0, 9'h0FF, 23'h000001, 0, 0, 0, 0, 0, 0, 0)); idle();
        expect_out("e_ff", 32'h7F80_0000, 1, 0, 1);
        send(mk(0, 9'h055, 23'h000000, 1, 1, 1, 1, 1, 1, 0)); idle();
        expect_out("prio_nan", 32'h7FC0_0000, 0, 0, 0);
        send(mk(1, 9'h055, 23'h000000, 1, 1, 1, 0, 1, 1, 0)); idle();
        expect_out("prio_inf", 32'hFF80_0000, 0, 0, 0);

        // Back-pressure: two entries fill the pipe, then the stall is released.
        for (int i = 0; i < 5; i++)
            bp[i] = mk(0, 9'h080 + 9'(i), 23'h010000 * 23'(i + 1), 0, 1, 0, 0, 0, 0, 0);
        out_ready = 1'b0;
        send(bp[0]);
        send(bp[1]);
        idle();
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_reassert", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        for (int i = 2; i < 5; i++) send(bp[i]);
        idle();
        drain();

        // Reset mid-flight discards both entries.
        send(mk(0, 9'h090, 23'h0ABCDE, 0, 0, 0, 0, 0, 0, 0));
        send(mk(1, 9'h091, 23'h012345, 0, 0, 0, 0, 0, 0, 0));
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_z", 64'(z), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(mk(0, 9'h07F, 23'h000000, 0, 0, 0, 0, 0, 0, 0));
        idle();
        @(negedge clk);
        check("latency_cycle1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("latency_cycle2", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        drain();

        // Randomized traffic with random back-pressure.
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom % 4) != 0;
                end
            end
        join_none
        for (int i = 0; i < 400; i++) begin
            send(rnd());
            if ($urandom % 3 == 0) begin
                idle();
                repeat ($urandom % 3) begin
                    @(posedge clk); #1;
                end
            end
        end
        idle();
        rand_on = 1'b0;
        repeat (2) @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_mult_round_pack.md
# fp_mult_round_pack

Final stage of the single-precision FP multiplier datapath. It takes the normalized 23-bit fraction, the 9-bit biased exponent and the guard/round/sticky bits from the normalize stage. It applies IEEE-754 round-to-nearest-even, renormalizes on rounding carry-out, resolves special cases and overflow/underflow, and packs a 32-bit result. It is a 2-stage valid/ready pipeline, so the multiplier can be back-pressured by its consumer.

## Interface
Parameters: none (single-precision only).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream holds a valid operand
- in_ready  out  1  stage 1 accepts data this cycle
- sign_in  in  1  product sign
- e_in  in  9  biased exponent after normalization; bit 8 set or value 255 means overflow
- m_in  in  23  fraction; hidden 1 implied
- g_in, r_in, sticky_in  in  1 each  guard, round and sticky bits below the fraction LSB
- nan_in, inf_in, zero_in, unf_in  in  1 each  special-case and underflow flags from upstream
- out_valid  out  1  z and flags valid
- out_ready  in  1  consumer accepts z this cycle
- z  out  32  packed result {sign, exp[7:0], frac[22:0]}
- ovf, unf, inexact  out  1 each  overflow, underflow and inexact flags, qualified by out_valid

## Operation
- Transfer occurs on a cycle where valid and ready are both high.
- in_ready = ~s1_valid | s1_adv.
- s1_adv = ~s2_valid | out_ready.
- Stage 1 (round) registers:
  - round_up = g_in & (r_in | sticky_in | m_in[0])
  - 25-bit sum = {1, m_in} + round_up; carry = sum[24]
  - e_in and the flags, unchanged
  - inexact = g_in | r_in | sticky_in
- Stage 2 (pack) renormalizes on carry: frac = 0 and e = e + 1. On no carry: frac = sum[22:0].
- Stage 2 selects the result by priority, first match wins:
  1. nan_in → z = 0x7FC00000; ovf = unf = inexact = 0
  2. inf_in → z = {sign, 0xFF, 0}; flags 0
  3. zero_in → z = {sign, 0x00, 0}; flags 0
  4. unf_in or final e == 0 → z = {sign, 0, 0}; unf = 1; inexact = 1. Flush-to-zero, no subnormals.
  5. final e >= 255, either because bit 8 is set or the value is 0xFF → z = {sign, 0xFF, 0}; ovf = 1; inexact = 1
  6. otherwise z = {sign, e[7:0], frac}, with inexact from stage 1
- Exponent arithmetic is 9-bit, so e = 0xFE plus a carry gives 0xFF, which is overflow.
- Ordering is strictly FIFO. Nothing is dropped or duplicated under back-pressure.

## Timing
- Latency is 2 cycles from input transfer to out_valid when out_ready = 1.
- Throughput is 1 result per cycle.
- Reset values: s1_valid = s2_valid = 0, out_valid = 0, z = 0, ovf = unf = inexact = 0. in_ready reads 1 in the cycle after reset deasserts.
- Reset mid-operation discards all in-flight data. No result for it ever appears.
- While out_valid = 1 and out_ready = 0:
  - z and the flags hold stable
  - stage 1 holds its contents
  - in_ready = ~s1_valid
- A pipeline full of 2 entries deasserts in_ready combinationally. It reasserts in the same cycle that out_ready rises.
- Simultaneous output transfer and input transfer are allowed. Occupancy stays the same.
- Stage 2 fed directly from stage 1 has no bubble.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to out_valid.

## Test plan
- Tie with odd LSB and carry: sign=0, e_in=0x7F, m_in=0x7FFFFF, g=1, r=0, sticky=0 → z=0x40000000 and inexact=1, two cycles later.
- Tie with even LSB: e_in=0x7F, m_in=0x000000, g=1, r=0, sticky=0 → z=0x3F800000, inexact=1. Same input with g=1, sticky=1 → z=0x3F800001.
- Overflow by rounding: sign=1, e_in=0xFE, m_in=0x7FFFFF, g=1, r=1 → z=0xFF800000, ovf=1, inexact=1. Separately, unf_in=1 → z=0x80000000 when sign=1, unf=1.
- Priority: nan_in=1, inf_in=1, zero_in=1 → z=0x7FC00000 with all flags 0. inf_in=1, zero_in=1, sign=1 → z=0xFF800000.
- Back-pressure: stream 5 distinct operands with out_ready=0 for cycles 2-6.
  - in_ready falls after 2 accepts.
  - All 5 results emerge in order with no loss or duplication.
  - z stays stable while stalled.
- Reset mid-flight: accept 2 operands, assert rst for 1 cycle → out_valid=0 and z=0 next cycle. No stale result appears afterwards, and the next operand has 2-cycle latency.
